// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the single-port
// 64-bit data memory.
//   Port A (a_*) : pipeline MEM stage.
//   Port B (b_*) : loader / debug DMA; b_lock holds the grant across a burst.
//   mem_*        : memory side; mem_read_data is combinational from memory.
// Each port gets a combinational grant (x_gnt). A read response arrives one
// cycle later as x_rvalid/x_rdata/x_err. A word address >= WORDS is flagged
// as out of range, and no memory strobe is issued for it.
// Build option: define ARB_STARVE_EN to force a single port A grant after
// STARVE_LIMIT cycles of lockout while port B holds the lock.
module dmem_arbiter #(
  parameter int unsigned WORDS        = 8192,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [63:0] a_addr,
  input  logic [63:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [63:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [63:0] b_addr,
  input  logic [63:0] b_wdata,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [63:0] b_rdata,
  output logic        b_err,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_read_data
);

  typedef enum logic {S_RR, S_LOCK} state_t;

  state_t      state, state_next;
  logic        last_gnt;          // 1: B held the most recent grant
  logic [63:0] addr_q, wdata_q;   // hold the memory bus while idle
  logic        a_in_range, b_in_range;
  logic        force_a;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be at least 1");
  end

  assign a_in_range = (a_addr < 64'(WORDS));
  assign b_in_range = (b_addr < 64'(WORDS));

`ifdef ARB_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_q;

  // Reaching LIMIT-1 arms a one-shot forced grant of A for the next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      force_q    <= 1'b0;
    end else if (state == S_LOCK && a_req && !a_gnt) begin
      if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
        starve_cnt <= '0;
        force_q    <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
        force_q    <= 1'b0;
      end
    end else begin
      starve_cnt <= '0;
      force_q    <= 1'b0;
    end
  end

  assign force_a = (state == S_LOCK) && force_q;
`else
  assign force_a = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_RR;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_RR:    if (b_gnt && b_lock)     state_next = S_LOCK;
      S_LOCK:  if (!b_req || !b_lock)   state_next = S_RR;
      default: state_next = S_RR;
    endcase
  end

  // Output logic: grant selection and memory port drive
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    case (state)
      S_RR: begin
        if (a_req && b_req) begin
          a_gnt = last_gnt;
          b_gnt = ~last_gnt;
        end else begin
          a_gnt = a_req;
          b_gnt = b_req;
        end
      end
      S_LOCK: begin
        if (force_a && a_req) a_gnt = 1'b1;
        else                  b_gnt = b_req;
      end
      default: ;
    endcase

    mem_address    = addr_q;
    mem_write_data = wdata_q;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (a_gnt) begin
      mem_address    = a_addr;
      mem_write_data = a_wdata;
      mem_write      = a_we & a_in_range;
      mem_read       = ~a_we & a_in_range;
    end else if (b_gnt) begin
      mem_address    = b_addr;
      mem_write_data = b_wdata;
      mem_write      = b_we & b_in_range;
      mem_read       = ~b_we & b_in_range;
    end
  end

  // Grant history, bus hold and registered read responses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      a_err    <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_err    <= 1'b0;
    end else begin
      if (a_gnt || b_gnt) begin
        last_gnt <= b_gnt;
        addr_q   <= mem_address;
        wdata_q  <= mem_write_data;
      end
      a_rvalid <= a_gnt & ~a_we;
      if (a_gnt && !a_we) begin
        a_rdata <= a_in_range ? mem_read_data : '0;
        a_err   <= ~a_in_range;
      end
      b_rvalid <= b_gnt & ~b_we;
      if (b_gnt && !b_we) begin
        b_rdata <= b_in_range ? mem_read_data : '0;
        b_err   <= ~b_in_range;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a small
// behavioural model of the 8192-word data memory.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_lock, b_gnt, b_rvalid, b_err;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        exp_a;
  int unsigned starve_cycles;
  int unsigned starve_hit;

  logic [63:0] mem [0:8191];
  logic        mem_ready = 1'b0;

  always #5 clock = ~clock;

  dmem_arbiter #(.WORDS(8192), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_err(b_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = (mem_address < 64'd8192) ? mem[mem_address[12:0]] : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= '0;
      mem[5]    <= 64'hDEAD;
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address[12:0]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_lock = 1'b0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) tick();
    check("rst_a_rvalid", 64'(a_rvalid), 64'd0);
    check("rst_a_rdata",  a_rdata, 64'd0);
    check("rst_b_rvalid", 64'(b_rvalid), 64'd0);
    check("rst_b_err",    64'(b_err), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_read",  64'(mem_read), 64'd0);
    reset_n = 1'b1;

    // Single A read of word 5
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'd5;
    #1;
    check("t1_a_gnt", 64'(a_gnt), 64'd1);
    check("t1_mem_read", 64'(mem_read), 64'd1);
    check("t1_mem_addr", mem_address, 64'd5);
    tick();
    a_req = 1'b0;
    check("t1_a_rvalid", 64'(a_rvalid), 64'd1);
    check("t1_a_rdata", a_rdata, 64'hDEAD);
    check("t1_a_err", 64'(a_err), 64'd0);
    tick();
    check("t1_rvalid_once", 64'(a_rvalid), 64'd0);
    check("t1_rdata_hold", a_rdata, 64'hDEAD);

    // Fresh reset, then contention: A writes word 10, B reads word 5
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("t2_rst_rdata", a_rdata, 64'd0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 64'd10; a_wdata = 64'hA1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 64'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_a = (i % 2 == 0);
      check("t2_a_gnt", 64'(a_gnt), 64'(exp_a));
      check("t2_b_gnt", 64'(b_gnt), 64'(!exp_a));
      check("t2_mem_write", 64'(mem_write), 64'(exp_a));
      check("t2_mem_read", 64'(mem_read), 64'(!exp_a));
      check("t2_mem_addr", mem_address, exp_a ? 64'd10 : 64'd5);
      if (i == 2) begin
        check("t2_b_rvalid", 64'(b_rvalid), 64'd1);
        check("t2_b_rdata", b_rdata, 64'hDEAD);
      end
      tick();
    end
    idle();
    #1;
    check("t2_idle_write", 64'(mem_write), 64'd0);
    check("t2_idle_read", 64'(mem_read), 64'd0);
    check("t2_addr_hold", mem_address, 64'd5);
    check("t2_a_rvalid", 64'(a_rvalid), 64'd0);

    // B: write last word, read one past the end, read the last word back
    b_req = 1'b1; b_we = 1'b1; b_addr = 64'd8191; b_wdata = 64'h11;
    #1;
    check("t3_b_gnt_w", 64'(b_gnt), 64'd1);
    check("t3_mem_write", 64'(mem_write), 64'd1);
    check("t3_mem_addr", mem_address, 64'd8191);
    tick();
    b_we = 1'b0; b_addr = 64'd8192;
    #1;
    check("t3_b_gnt_r", 64'(b_gnt), 64'd1);
    check("t3_oor_read", 64'(mem_read), 64'd0);
    check("t3_oor_write", 64'(mem_write), 64'd0);
    tick();
    b_addr = 64'd8191;
    check("t3_b_rvalid", 64'(b_rvalid), 64'd1);
    check("t3_b_rdata", b_rdata, 64'd0);
    check("t3_b_err", 64'(b_err), 64'd1);
    tick();
    b_req = 1'b0;
    check("t3_b_readback", b_rdata, 64'h11);
    check("t3_b_err_clr", 64'(b_err), 64'd0);

    // A: read back word 10, then an address with only high bits out of range
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'd10;
    tick();
    check("t3_a_readback", a_rdata, 64'hA1);
    check("t3_a_err", 64'(a_err), 64'd0);
    a_addr = 64'h1_0000_0005;
    #1;
    check("t3_hi_mem_read", 64'(mem_read), 64'd0);
    tick();
    a_req = 1'b0;
    check("t3_hi_rvalid", 64'(a_rvalid), 64'd1);
    check("t3_hi_err", 64'(a_err), 64'd1);
    check("t3_hi_rdata", a_rdata, 64'd0);

    // B locked burst of 6 writes while A keeps requesting
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'd5;
    b_req = 1'b1; b_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_addr = 64'(20 + i); b_wdata = 64'(i); b_lock = (i < 5);
      #1;
      check("t4_b_gnt", 64'(b_gnt), 64'd1);
      check("t4_a_gnt", 64'(a_gnt), 64'd0);
      tick();
    end
    b_req = 1'b0; b_lock = 1'b0;
    #1;
    check("t4_a_after", 64'(a_gnt), 64'd1);
    tick();
    a_req = 1'b0;

    // Reset between a granted A read and its response
    check("t5_pre_rdata", a_rdata, 64'hDEAD);
    a_req = 1'b1; a_addr = 64'd5;
    #1;
    check("t5_a_gnt", 64'(a_gnt), 64'd1);
    #2;
    reset_n = 1'b0;
    tick();
    a_req = 1'b0;
    check("t5_rvalid", 64'(a_rvalid), 64'd0);
    check("t5_rdata", a_rdata, 64'd0);
    reset_n = 1'b1;

    // Reset releases an active lock
    b_req = 1'b1; b_lock = 1'b1; b_we = 1'b0; b_addr = 64'd5;
    tick();
    reset_n = 1'b0; #1; reset_n = 1'b1;
    a_req = 1'b1; a_addr = 64'd5;
    #1;
    check("t5_unlock_a", 64'(a_gnt), 64'd1);
    check("t5_unlock_b", 64'(b_gnt), 64'd0);
    tick();
    idle();
    tick();

    // Starvation: B locked, A requesting throughout
    b_req = 1'b1; b_lock = 1'b1; b_we = 1'b0; b_addr = 64'd5;
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'd5;
`ifdef ARB_STARVE_EN
    starve_cycles = 6;
    starve_hit    = 4;
`else
    starve_cycles = 20;
    starve_hit    = 999;
`endif
    for (int i = 0; i < 20; i++) begin
      if (i < int'(starve_cycles)) begin
        #1;
        exp_a = (i == int'(starve_hit));
        check("t6_a_gnt", 64'(a_gnt), 64'(exp_a));
        check("t6_b_gnt", 64'(b_gnt), 64'(!exp_a));
        tick();
      end
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
